// File: rtl/mips_regwrite_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU and load writeback,
// with a 32-entry pending-write scoreboard that drives the decode RAW stall.
module mips_regwrite_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        rsv_en,
    input  logic [4:0]  rsv_addr,
    input  logic [4:0]  chk_rs,
    input  logic [4:0]  chk_rt,
    output logic        stall,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] busy
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_t;

    src_t        last;
    logic        grant;
    src_t        grant_src;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic [31:0] busy_next;

    // On a tie the requester that did not win most recently takes the port.
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        if (alu_valid && ld_valid) begin
            if (last == SRC_LD) alu_ready = 1'b1;
            else                ld_ready  = 1'b1;
        end else begin
            alu_ready = alu_valid;
            ld_ready  = ld_valid;
        end
    end

    always_comb begin
        grant     = alu_ready | ld_ready;
        grant_src = ld_ready ? SRC_LD : SRC_ALU;
        sel_addr  = ld_ready ? ld_addr : alu_addr;
        sel_data  = ld_ready ? ld_data : alu_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= SRC_LD;
            wr_en   <= 1'b0;
            wr_addr <= 5'd0;
            wr_data <= 32'd0;
        end else if (grant) begin
            last    <= grant_src;
            wr_en   <= (sel_addr != 5'd0);
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Clear applied before set so a same-edge reservation of the written register survives.
    always_comb begin
        busy_next = busy;
        if (wr_en) busy_next[wr_addr] = 1'b0;
        if (rsv_en && (rsv_addr != 5'd0)) busy_next[rsv_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= 32'd0;
        else        busy <= busy_next;
    end

    assign stall = busy[chk_rs] | busy[chk_rt];

endmodule

// File: tb/tb_mips_regwrite_arbiter.sv
// Bench for mips_regwrite_arbiter: directed sequences plus a behavioural
// model compared against the DUT on every falling clock edge.
module tb_mips_regwrite_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  chk_rs;
    logic [4:0]  chk_rt;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy;

    int passed = 0;
    int total  = 0;

    mips_regwrite_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .chk_rs(chk_rs), .chk_rt(chk_rt),
        .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Model state: who won last (0 = ALU, 1 = load), pending-write set, write port.
    int          m_last_winner = 1;
    bit          m_pending [32];
    bit          m_wr_en   = 0;
    int          m_wr_addr = 0;
    logic [31:0] m_wr_data = 0;

    function automatic int winner();
        if (alu_valid && ld_valid) return (m_last_winner == 1) ? 0 : 1;
        if (alu_valid) return 0;
        if (ld_valid) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] pending_vec();
        logic [31:0] v = 0;
        for (int i = 1; i < 32; i++) if (m_pending[i]) v = v | (32'd1 << i);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last_winner = 1;
            for (int i = 0; i < 32; i++) m_pending[i] = 0;
            m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
        end else begin
            int w;
            int a;
            w = winner();
            if (m_wr_en) m_pending[m_wr_addr] = 0;
            if (rsv_en && rsv_addr != 0) m_pending[rsv_addr] = 1;
            if (w >= 0) begin
                a = (w == 0) ? int'(alu_addr) : int'(ld_addr);
                m_wr_data = (w == 0) ? alu_data : ld_data;
                m_wr_addr = a;
                m_wr_en = (a != 0);
                m_last_winner = w;
            end else begin
                m_wr_en = 0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        w = winner();
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, w == 0});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, w == 1});
        chk("wr_en", {31'd0, wr_en}, {31'd0, m_wr_en});
        chk("wr_addr", {27'd0, wr_addr}, m_wr_addr);
        chk("wr_data", wr_data, m_wr_data);
        chk("busy", busy, pending_vec());
        chk("stall", {31'd0, stall}, {31'd0, m_pending[chk_rs] | m_pending[chk_rt]});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        rsv_en = 0; rsv_addr = 0; chk_rs = 0; chk_rt = 0;
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        step(); step();
        rst_n = 1'b1;

        // Round robin: ALU first after reset, then strict alternation.
        alu_valid = 1; alu_addr = 5; alu_data = 32'hAAAA_0001;
        ld_valid = 1; ld_addr = 6; ld_data = 32'h5555_0002;
        #1;
        chk("rr_first_alu_ready", {31'd0, alu_ready}, 1);
        chk("rr_first_ld_ready", {31'd0, ld_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_wr_en", {31'd0, wr_en}, 1);
            chk("rr_wr_addr", {27'd0, wr_addr}, (i % 2 == 0) ? 5 : 6);
        end
        alu_valid = 0; ld_valid = 0;

        // Register zero: accepted but no write, reservation ignored.
        alu_valid = 1; alu_addr = 0; alu_data = 32'hDEAD_BEEF;
        #1;
        chk("r0_alu_ready", {31'd0, alu_ready}, 1);
        step();
        alu_valid = 0;
        chk("r0_wr_en", {31'd0, wr_en}, 0);
        chk("r0_wr_data", wr_data, 32'hDEAD_BEEF);
        rsv_en = 1; rsv_addr = 0;
        step();
        rsv_en = 0;
        chk("r0_busy", busy, 0);

        // Scoreboard life cycle on r9.
        rsv_en = 1; rsv_addr = 9; chk_rs = 9;
        step();
        rsv_en = 0;
        chk("sb_busy_set", busy, 32'h0000_0200);
        chk("sb_stall_set", {31'd0, stall}, 1);
        ld_valid = 1; ld_addr = 9; ld_data = 32'h1234;
        #1;
        chk("sb_ld_ready", {31'd0, ld_ready}, 1);
        step();
        ld_valid = 0;
        chk("sb_e0_wr_en", {31'd0, wr_en}, 1);
        chk("sb_e0_wr_addr", {27'd0, wr_addr}, 9);
        chk("sb_e0_stall", {31'd0, stall}, 1);
        step();
        chk("sb_e1_busy", busy, 0);
        chk("sb_e1_stall", {31'd0, stall}, 0);

        // Set wins over clear on r3; clear of r3 with set of r4 both apply.
        rsv_en = 1; rsv_addr = 3;
        step();
        rsv_en = 0;
        alu_valid = 1; alu_addr = 3; alu_data = 32'h33;
        step();
        alu_valid = 0;
        rsv_en = 1; rsv_addr = 3;
        step();
        rsv_en = 0;
        chk("soc_busy3", busy, 32'h0000_0008);
        alu_valid = 1; alu_addr = 3; alu_data = 32'h34;
        step();
        alu_valid = 0;
        rsv_en = 1; rsv_addr = 4; chk_rt = 4;
        step();
        rsv_en = 0;
        chk("soc_busy4", busy, 32'h0000_0010);
        chk("soc_stall_rt", {31'd0, stall}, 1);

        // Idle hold after a load write to r7; tie then goes to the ALU.
        ld_valid = 1; ld_addr = 7; ld_data = 32'hFF;
        step();
        ld_valid = 0;
        chk("idle_wr_en_first", {31'd0, wr_en}, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_wr_en", {31'd0, wr_en}, 0);
            chk("idle_wr_addr", {27'd0, wr_addr}, 7);
            chk("idle_wr_data", wr_data, 32'hFF);
        end
        alu_valid = 1; alu_addr = 1; alu_data = 32'h1;
        ld_valid = 1; ld_addr = 2; ld_data = 32'h2;
        #1;
        chk("idle_tie_alu_ready", {31'd0, alu_ready}, 1);
        chk("idle_tie_ld_ready", {31'd0, ld_ready}, 0);
        step();
        alu_valid = 0; ld_valid = 0;
        chk("idle_tie_wr_addr", {27'd0, wr_addr}, 1);

        // Reset mid-stream with wr_en high and busy = 0x0F00.
        ld_valid = 1; ld_addr = 4; ld_data = 32'h4;
        rsv_en = 1; rsv_addr = 8;
        step();
        ld_valid = 0; rsv_addr = 9;
        step();
        rsv_addr = 10;
        step();
        rsv_addr = 11; alu_valid = 1; alu_addr = 12; alu_data = 32'hC;
        step();
        rsv_en = 0; ld_valid = 1; ld_addr = 13; ld_data = 32'hD;
        chk("pre_rst_busy", busy, 32'h0000_0F00);
        chk("pre_rst_wr_en", {31'd0, wr_en}, 1);
        #1;
        rst_n = 0;
        #1;
        chk("mid_rst_wr_en", {31'd0, wr_en}, 0);
        chk("mid_rst_wr_addr", {27'd0, wr_addr}, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_stall", {31'd0, stall}, 0);
        chk("mid_rst_alu_ready", {31'd0, alu_ready}, 1);
        chk("mid_rst_ld_ready", {31'd0, ld_ready}, 0);
        step(); step();
        #2;
        rst_n = 1;
        step();
        chk("post_rst_wr_en", {31'd0, wr_en}, 1);
        chk("post_rst_wr_addr", {27'd0, wr_addr}, 12);
        chk("post_rst_ld_ready", {31'd0, ld_ready}, 1);
        alu_valid = 0; ld_valid = 0;
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_regwrite_arbiter.md
# mips_regwrite_arbiter

Arbitrates the single register-file write port between two writeback requesters: ALU results and load results. Keeps a 32-entry pending-write scoreboard so decode can stall on RAW hazards. Sits between the execute/memory stages and the register file write port (write enable, rt-style write address, write data). Issues one registered write per cycle with round-robin fairness.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register address, 32 registers.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU writeback request pending.
- `alu_addr` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: ALU request accepted this cycle. Combinational.
- `ld_valid` in 1: load writeback request pending.
- `ld_addr` in 5: load destination register.
- `ld_data` in 32: load result.
- `ld_ready` out 1: load request accepted this cycle. Combinational.
- `rsv_en` in 1: decode reserves a destination register.
- `rsv_addr` in 5: register being reserved.
- `chk_rs` in 5: decode source address to check.
- `chk_rt` in 5: decode source address to check.
- `stall` out 1: combinational. Equals busy[chk_rs] OR busy[chk_rt].
- `wr_en` out 1: registered write enable to the register file.
- `wr_addr` out 5: registered write address.
- `wr_data` out 32: registered write data.
- `busy` out 32: scoreboard vector; bit n = write to register n pending.

## Operation
- **Handshake:** a requester holds valid, addr and data stable until it sees ready high. The transfer occurs on the clock edge where valid and ready are both high.
- **Arbitration:**
  - Only one requester is pending: it is granted.
  - Both are pending: grant the one that was not granted most recently. This uses a 1-bit `last` pointer.
  - `last` updates only on an actual grant.
  - Reset value of `last` is the load requester, so the ALU wins the first tie.
- **Ready:** `alu_ready` = grant to ALU. `ld_ready` = grant to load. At most one is high in any cycle.
- **Write capture:** on a grant edge, register the requester's addr and data into `wr_addr`/`wr_data`.
  - `wr_en` <= 1, unless the address is 0.
  - A write to address 0 is accepted (ready high) but produces `wr_en` = 0. `wr_addr`/`wr_data` still update.
- **No grant:** `wr_en` <= 0. `wr_addr` and `wr_data` hold their values.
- **Scoreboard:**
  - `rsv_en` sets busy[rsv_addr] at the edge.
  - A cycle with `wr_en` = 1 clears busy[wr_addr] at the edge ending that cycle.
  - Reservation of address 0 is ignored. busy[0] is constantly 0.
  - Set and clear hit the same register at the same edge: set wins. The new reservation is the younger write.
  - Re-reserving a register that is already busy leaves it busy. There is no counter; decode stalls issue until the register is free.
- **Stall:** `stall` is purely combinational from the current busy vector. No internal bypass.
- **Independence:** requests are not checked against the scoreboard. Arbitration is independent of `busy`.

## Timing
- **Reset (asynchronous, immediate):**
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `busy`=0, so `stall`=0.
  - `last`=load.
  - Ready outputs follow the valids combinationally even during reset deassertion.
- **Reset mid-operation:**
  - An in-flight `wr_en` is dropped.
  - Scoreboard bits are lost.
  - Requesters must re-present after `rst_n` rises.
- **Latency:**
  - Accept edge E0 drives `wr_*` during cycle E0..E1; the register file writes at E1.
  - busy clears at E1. `stall` for that register falls in the cycle after E1, so decode then reads the committed value.
- **Throughput:** one accepted write per cycle. Both valids held continuously give strict alternation: ALU, load, ALU, …
- **Simultaneous reserve and clear:** same-edge reserve and clear of different registers are both applied.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n`=0 mid-stream with `wr_en`=1 and busy=0x0000_0F00.
  - Required: outputs go to zero immediately, with no clock. After release, ALU and load both valid → ALU granted first.
- **Round-robin:**
  - Stimulus: both valid for 4 cycles, ALU addr 5 / data 0xAAAA_0001, load addr 6 / data 0x5555_0002.
  - Required: `wr_addr` sequence 5, 6, 5, 6 with `wr_en` high each cycle, and exactly one ready per cycle.
- **Register zero:**
  - Stimulus: ALU-only request to addr 0, data 0xDEADBEEF; then `rsv_en` with addr 0.
  - Required: `alu_ready`=1, next-cycle `wr_en`=0, busy stays 0.
- **Scoreboard life cycle:**
  - Stimulus: reserve r9; set `chk_rs`=9; load writes r9 with data 0x1234 accepted at edge E0.
  - Required: `stall` high from the cycle after reserve; `wr_en`/`wr_addr`=9 during E0..E1; busy[9] clears at E1; `stall` low after E1.
- **Set-over-clear:**
  - Stimulus: the cycle with `wr_en`=1 for r3 also has `rsv_en` for r3.
  - Required: busy[3] remains 1.
- **Idle hold:**
  - Stimulus: after a write of 0x0000_00FF to r7, no valids for 3 cycles.
  - Required: `wr_en`=0 while `wr_addr`=7 and `wr_data`=0xFF hold; `last` does not change, so the next tie still goes to the non-last requester.
